// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and widths for the LC-3 memory responder
package lc3_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
  localparam int WORD_W     = 16;
  localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/lc3_sram_array.sv
// rtl/lc3_sram_array.sv - single-port synchronous word RAM, registered read, no reset
module lc3_sram_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read-first: a same-cycle write is not visible on rdata until the next access.
  always_ff @(posedge Clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - MAR/MDR memory responder with programmable wait states
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = WORD_W
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [15:0]       MAR,
  input  logic [DATA_W-1:0] MDR_in,
  output logic [DATA_W-1:0] MDR_out,
  output logic              R,
  output logic              busy
);
  mem_state_t            state;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  rw_q;
  logic                  sel_ram;
  logic [DATA_W-1:0]     hold_q;
  logic [DATA_W-1:0]     rdata;
  logic                  accept_now;
  logic                  access;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic                  unused_mar_hi;

  assign unused_mar_hi = ^MAR[15:ADDR_W];

  // With zero wait states the access happens on the accepting edge, so the
  // RAM is fed straight from the request inputs while IDLE.
  assign accept_now = (state == IDLE) && MIO_EN && (WAIT_CYCLES == 0);
  assign access     = accept_now ||
                      ((state == BUSY) && MIO_EN && (cnt_q == WAIT_CNT_W'(1)));
  assign ram_addr   = (state == IDLE) ? MAR[ADDR_W-1:0] : addr_q;
  assign ram_wdata  = (state == IDLE) ? MDR_in : wdata_q;
  assign ram_we     = access && !reset && ((state == IDLE) ? R_W : rw_q);

  lc3_sram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .Clk   (Clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (rdata)
  );

  // After a read the RAM output is shown directly; hold_q keeps it once the
  // RAM address starts following MAR again in IDLE.
  assign MDR_out = sel_ram ? rdata : hold_q;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state   <= IDLE;
      R       <= 1'b0;
      busy    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      sel_ram <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MIO_EN) begin
            addr_q  <= MAR[ADDR_W-1:0];
            wdata_q <= MDR_in;
            rw_q    <= R_W;
            cnt_q   <= WAIT_CNT_W'(WAIT_CYCLES);
            busy    <= 1'b1;
            if (accept_now) begin
              state   <= DONE;
              R       <= 1'b1;
              sel_ram <= !R_W;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!MIO_EN) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt_q <= '0;
          end else if (access) begin
            state   <= DONE;
            R       <= 1'b1;
            sel_ram <= !rw_q;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - WAIT_CNT_W'(1);
          end
        end
        DONE: begin
          if (sel_ram) hold_q <= rdata;
          if (!MIO_EN) begin
            state   <= IDLE;
            R       <= 1'b0;
            busy    <= 1'b0;
            sel_ram <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb/tb_lc3_mem_responder.sv - randomized self-checking bench for lc3_mem_responder
module tb_lc3_mem_responder;
  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  en = 2'b00;
  logic        R_W = 1'b0;
  logic [15:0] MAR = 16'h0000;
  logic [15:0] MDR_in = 16'h0000;
  logic [1:0]  r_o;
  logic [1:0]  busy_o;
  logic [15:0] mdr_o [2];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: word array and last read value per responder instance.
  logic [15:0] mem_m [2][1024];
  logic [15:0] mdr_m [2];
  int          wait_of [2];

  always #5 Clk = ~Clk;

  lc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
    .Clk(Clk), .reset(reset), .MIO_EN(en[0]), .R_W(R_W), .MAR(MAR),
    .MDR_in(MDR_in), .MDR_out(mdr_o[0]), .R(r_o[0]), .busy(busy_o[0])
  );

  lc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (
    .Clk(Clk), .reset(reset), .MIO_EN(en[1]), .R_W(R_W), .MAR(MAR),
    .MDR_in(MDR_in), .MDR_out(mdr_o[1]), .R(r_o[1]), .busy(busy_o[1])
  );

  task automatic scramble();
    R_W    = 1'($urandom);
    MAR    = 16'($urandom);
    MDR_in = 16'($urandom);
  endtask

  task automatic txn(input int w, input logic rw, input logic [15:0] mar,
                     input logic [15:0] din, input int hold, input bit abort);
    @(negedge Clk);
    en[w] = 1'b1; R_W = rw; MAR = mar; MDR_in = din;
    if (abort) begin
      @(negedge Clk);
      scramble();
      n_chk++;
      if (r_o[w] !== 1'b0 || busy_o[w] !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_busy[%0d]: R=%b busy=%b expected R=0 busy=1", w, r_o[w], busy_o[w]);
      end
      en[w] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge Clk);
        n_chk++;
        if (r_o[w] !== 1'b0 || busy_o[w] !== 1'b0 || mdr_o[w] !== mdr_m[w]) begin
          n_fail++;
          $display("FAIL abort_idle[%0d]: R=%b busy=%b MDR_out=%h expected R=0 busy=0 MDR_out=%h",
                   w, r_o[w], busy_o[w], mdr_o[w], mdr_m[w]);
        end
      end
      return;
    end
    for (int k = 1; k <= wait_of[w] + 1; k++) begin
      @(negedge Clk);
      scramble();
      n_chk++;
      if (r_o[w] !== (k == wait_of[w] + 1)) begin
        n_fail++;
        $display("FAIL latency[%0d] cycle %0d: R=%b expected %b", w, k, r_o[w], (k == wait_of[w] + 1));
      end
    end
    if (rw) mem_m[w][mar[9:0]] = din;
    else    mdr_m[w] = mem_m[w][mar[9:0]];
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) begin
        @(negedge Clk);
        scramble();
      end
      n_chk++;
      if (r_o[w] !== 1'b1 || busy_o[w] !== 1'b1 || mdr_o[w] !== mdr_m[w]) begin
        n_fail++;
        $display("FAIL done[%0d] addr %h: R=%b busy=%b MDR_out=%h expected R=1 busy=1 MDR_out=%h",
                 w, mar, r_o[w], busy_o[w], mdr_o[w], mdr_m[w]);
      end
    end
    en[w] = 1'b0;
    @(negedge Clk);
    n_chk++;
    if (r_o[w] !== 1'b0 || busy_o[w] !== 1'b0 || mdr_o[w] !== mdr_m[w]) begin
      n_fail++;
      $display("FAIL release[%0d]: R=%b busy=%b MDR_out=%h expected R=0 busy=0 MDR_out=%h",
               w, r_o[w], busy_o[w], mdr_o[w], mdr_m[w]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    mdr_m[0] = 16'h0000; mdr_m[1] = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if (r_o[w] !== 1'b0 || busy_o[w] !== 1'b0 || mdr_o[w] !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_idle[%0d]: R=%b busy=%b MDR_out=%h expected 0 0 0000",
                   w, r_o[w], busy_o[w], mdr_o[w]);
        end
      end
    end
  endtask

  task automatic test_prefill();
    logic [9:0] pool [5];
    pool[0] = 10'h010; pool[1] = 10'h020; pool[2] = 10'h030;
    pool[3] = 10'h3FF; pool[4] = 10'h000;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 5; i++)
        txn(w, 1'b1, {6'd0, pool[i]}, 16'(16'h1000 * i + 16'h0101 * w + 16'h0055), 0, 1'b0);
  endtask

  task automatic test_write_read();
    txn(0, 1'b1, 16'h0010, 16'h1234, 0, 1'b0);
    txn(0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_hold();
    txn(0, 1'b0, 16'h0010, 16'h0000, 6, 1'b0);
  endtask

  task automatic test_abort();
    txn(0, 1'b1, 16'h0020, 16'h5555, 0, 1'b0);
    txn(0, 1'b1, 16'h0020, 16'hBEEF, 0, 1'b1);
    txn(0, 1'b0, 16'h0020, 16'h0000, 1, 1'b0);
  endtask

  task automatic test_alias();
    txn(0, 1'b1, 16'h0400, 16'hA5A5, 0, 1'b0);
    txn(0, 1'b0, 16'h0000, 16'h0000, 0, 1'b0);
    txn(1, 1'b1, 16'hFC00, 16'h5A5A, 0, 1'b0);
    txn(1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    en[0] = 1'b1; R_W = 1'b1; MAR = 16'h0030; MDR_in = 16'h7777;
    @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0; en[0] = 1'b0;
    mdr_m[0] = 16'h0000; mdr_m[1] = 16'h0000;
    for (int w = 0; w < 2; w++) begin
      n_chk++;
      if (r_o[w] !== 1'b0 || busy_o[w] !== 1'b0 || mdr_o[w] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: R=%b busy=%b MDR_out=%h expected 0 0 0000",
                 w, r_o[w], busy_o[w], mdr_o[w]);
      end
    end
    txn(0, 1'b0, 16'h0030, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_wait0();
    txn(1, 1'b1, 16'h0030, 16'hC0DE, 0, 1'b0);
    txn(1, 1'b0, 16'h0030, 16'h0000, 2, 1'b0);
    txn(1, 1'b1, 16'h0030, 16'h1357, 0, 1'b0);
    txn(1, 1'b0, 16'h0030, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [9:0] pool [5];
    int w;
    pool[0] = 10'h010; pool[1] = 10'h020; pool[2] = 10'h030;
    pool[3] = 10'h3FF; pool[4] = 10'h000;
    for (int i = 0; i < 60; i++) begin
      w = int'($urandom_range(0, 1));
      txn(w, 1'($urandom), {6'($urandom), pool[$urandom_range(0, 4)]}, 16'($urandom),
          int'($urandom_range(0, 3)), (w == 0) && ($urandom_range(0, 5) == 0));
    end
  endtask

  initial begin
    wait_of[0] = 2; wait_of[1] = 0;
    mdr_m[0] = 16'h0000; mdr_m[1] = 16'h0000;
    test_reset();
    test_prefill();
    test_write_read();
    test_hold();
    test_abort();
    test_alias();
    test_reset_mid();
    test_wait0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC-3 datapath's MAR/MDR memory interface.
- The CPU control FSM initiates a read or write by asserting MIO_EN. The responder latches the request, inserts a programmable number of wait states, performs the access on an internal word array, then raises R (ready).
- Sits between the datapath (MAR/MDR registers) and on-chip RAM. It replaces a zero-latency memory model so control-FSM wait loops are exercised.

Parameters:
- ADDR_W, 10, number of address bits used; array depth = 2**ADDR_W words.
- WAIT_CYCLES, 2, wait states between request acceptance and R assertion (0..15).
- DATA_W, 16, word width; fixed at 16 for LC-3.

Ports:
- Clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- MIO_EN  in  1  request valid from control FSM; held high until R is seen.
- R_W  in  1  1 = write, 0 = read; sampled at acceptance.
- MAR  in  16  word address; only MAR[ADDR_W-1:0] used.
- MDR_in  in  16  write data from MDR; sampled at acceptance.
- MDR_out  out  16  read data toward MDR input mux.
- R  out  1  ready/done; high while in DONE state.
- busy  out  1  high in BUSY or DONE (debug/visibility).

Behaviour:
- Reset: state=IDLE, R=0, busy=0, MDR_out=16'h0000, wait counter=0. Array contents are not reset.
- States: IDLE, BUSY, DONE.
- IDLE with MIO_EN=1:
  - latch addr=MAR[ADDR_W-1:0], wdata=MDR_in, rw=R_W; load counter=WAIT_CYCLES.
  - go to BUSY, or directly to DONE if WAIT_CYCLES=0.
- BUSY:
  - counter decrements each cycle.
  - when counter==1 (or on entry with WAIT_CYCLES=0), perform the access and go to DONE.
- Access:
  - write: array[addr] <= wdata; MDR_out unchanged.
  - read: MDR_out <= array[addr].
  - the access occurs on the same edge that enters DONE.
- Latency: R is first high WAIT_CYCLES+1 cycles after the edge on which MIO_EN was sampled high in IDLE.
- DONE: R=1; MDR_out is stable and valid for reads. Stay in DONE while MIO_EN=1; go to IDLE on the first cycle MIO_EN=0. No new request is accepted from DONE.
- Back-to-back requests: MIO_EN must be low for at least one cycle, which is guaranteed by the LC-3 FSM. A request is accepted on the first IDLE cycle with MIO_EN=1.
- Abort: MIO_EN falling while BUSY → return to IDLE next cycle. No array write, MDR_out unchanged, R never asserted.
- Reset mid-operation: in any state, return to IDLE and clear MDR_out. A pending write is discarded; array contents are otherwise preserved.
- Address wrap: MAR bits above ADDR_W-1 are ignored, so 16'h0400 aliases 16'h0000 when ADDR_W=10.
- Inputs changing during BUSY/DONE: ignored; the latched values govern.
- Read-after-write to the same address in consecutive transactions returns the new data.
- MDR_out holds the last read value between transactions.

Decomposition:
- Package lc3_mem_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t
  - localparam WORD_W=16
  - localparam WAIT_CNT_W=4
- Sub-module lc3_sram_array: single-port synchronous RAM with ADDR_W, DATA_W, we, addr, wdata, rdata registered on posedge, no reset. The responder instantiates one copy and owns the FSM, counter and latches.

Test Plan:
- Reset then idle: hold reset 2 cycles, MIO_EN=0 → R=0, busy=0, MDR_out=0x0000 for 5 cycles.
- Write then read, WAIT_CYCLES=2:
  - MAR=0x0010, MDR_in=0x1234, R_W=1, MIO_EN=1 → R high exactly 3 cycles after acceptance.
  - drop MIO_EN → IDLE.
  - read 0x0010 → MDR_out=0x1234 when R rises.
- Hold in DONE: keep MIO_EN=1 for 6 cycles after R rises → R stays 1 and MDR_out stable. Drop MIO_EN → R=0 next cycle.
- Abort:
  - write 0x0020 ← 0xBEEF; drop MIO_EN after 1 BUSY cycle → R never rises.
  - subsequent read of 0x0020 → prior contents (pre-written 0x5555).
- Address alias, ADDR_W=10: write MAR=0x0400 ← 0xA5A5; read MAR=0x0000 → 0xA5A5.
- Reset mid-BUSY plus WAIT_CYCLES=0 variant:
  - reset during write of 0x0030 ← 0x7777 → R=0, MDR_out=0, address 0x0030 unchanged.
  - with WAIT_CYCLES=0, R rises 1 cycle after acceptance.
